// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract controller, LSB first, one bit per clock
// addsub_halffull is the shared one-bit add/subtract cell; serial_addsub_ctrl sequences it.

module addsub_halffull (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_mode_addsub,
  input  logic i_mode_halffull,
  output logic o_s,
  output logic o_c
);

  logic w_c_eff;

  // Half mode ignores the incoming carry/borrow entirely.
  assign w_c_eff = i_c & i_mode_halffull;
  assign o_s     = i_a ^ i_b ^ w_c_eff;
  assign o_c     = (w_c_eff & (i_a ^ i_b ^ i_mode_addsub)) | ((i_a ^ i_mode_addsub) & i_b);

endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_addsub,
  input  logic             mode_halffull,
  input  logic             carryborrow_in,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryborrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode_addsub;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cbout;
  logic             r_ovf;

  logic w_bit_a;
  logic w_bit_b;
  logic w_sum;
  logic w_c_next;
  logic w_last;
  logic w_accept;

  assign w_bit_a  = r_a[r_cnt];
  assign w_bit_b  = r_b[r_cnt];
  assign w_last   = (r_cnt == LAST_IDX);
  assign w_accept = (r_state == S_IDLE) && start;

  // Half/full selection is folded into r_c at capture, so the cell always runs in full mode.
  addsub_halffull u_cell (
    .i_a             (w_bit_a),
    .i_b             (w_bit_b),
    .i_c             (r_c),
    .i_mode_addsub   (r_mode_addsub),
    .i_mode_halffull (1'b1),
    .o_s             (w_sum),
    .o_c             (w_c_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a           <= '0;
      r_b           <= '0;
      r_mode_addsub <= 1'b0;
      r_c           <= 1'b0;
      r_cnt         <= '0;
      r_result      <= '0;
      r_cbout       <= 1'b0;
      r_ovf         <= 1'b0;
    end else if (w_accept) begin
      r_a           <= operand_a;
      r_b           <= operand_b;
      r_mode_addsub <= mode_addsub;
      r_c           <= carryborrow_in & mode_halffull;
      r_cnt         <= '0;
    end else if (r_state == S_RUN) begin
      // Bits are written in place, so the previous result stays visible until overwritten.
      r_result[r_cnt] <= w_sum;
      r_c             <= w_c_next;
      r_cnt           <= r_cnt + CW'(1);
      if (w_last) begin
        r_cbout <= w_c_next;
        r_ovf   <= r_c ^ w_c_next;
      end
    end
  end

  assign result          = r_result;
  assign carryborrow_out = r_cbout;
  assign overflow        = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - directed self-checking bench for serial_addsub_ctrl (WIDTH=8)

module tb_serial_addsub_ctrl;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset;
  logic             start;
  logic             mode_addsub;
  logic             mode_halffull;
  logic             carryborrow_in;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryborrow_out;
  logic             overflow;

  int errors;
  int checks;

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .mode_addsub     (mode_addsub),
    .mode_halffull   (mode_halffull),
    .carryborrow_in  (carryborrow_in),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .carryborrow_out (carryborrow_out),
    .overflow        (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses start for one edge, then counts edges until done is seen (bounded).
  task automatic run_op(input logic m_sub, input logic m_full, input logic cin,
                        input logic [7:0] a, input logic [7:0] b, output int lat);
    mode_addsub    = m_sub;
    mode_halffull  = m_full;
    carryborrow_in = cin;
    operand_a      = a;
    operand_b      = b;
    start          = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b required busy=0 done=0", busy, done);
    end
    checks++;
    if (result !== 8'h00 || carryborrow_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_data result=%h cbo=%b ovf=%b required 00 0 0", result, carryborrow_out, overflow);
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(1'b0, 1'b1, 1'b0, 8'h7F, 8'h01, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL add_latency got=%0d required=8", lat);
    end
    checks++;
    if (result !== 8'h80 || carryborrow_out !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL add_7f_01 result=%h cbo=%b ovf=%b required 80 0 1", result, carryborrow_out, overflow);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_done got=%b required=1", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle done=%b busy=%b required 0 0", done, busy);
    end
    tick();
    tick();
    checks++;
    if (result !== 8'h80 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL hold_idle result=%h ovf=%b required 80 1", result, overflow);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(1'b1, 1'b1, 1'b0, 8'h05, 8'h07, lat);
    checks++;
    if (lat !== 8 || result !== 8'hFE || carryborrow_out !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_05_07 lat=%0d result=%h cbo=%b ovf=%b required 8 fe 1 0", lat, result, carryborrow_out, overflow);
    end
    tick();
    run_op(1'b1, 1'b1, 1'b0, 8'h80, 8'h01, lat);
    checks++;
    if (lat !== 8 || result !== 8'h7F || carryborrow_out !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sub_80_01 lat=%0d result=%h cbo=%b ovf=%b required 8 7f 0 1", lat, result, carryborrow_out, overflow);
    end
    tick();
    run_op(1'b1, 1'b1, 1'b1, 8'h10, 8'h01, lat);
    checks++;
    if (result !== 8'h0E || carryborrow_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_bin_10_01 result=%h cbo=%b ovf=%b required 0e 0 0", result, carryborrow_out, overflow);
    end
    tick();
  endtask

  task automatic test_halffull();
    int lat;
    run_op(1'b0, 1'b1, 1'b1, 8'hFF, 8'h01, lat);
    checks++;
    if (result !== 8'h01 || carryborrow_out !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL add_full_cin result=%h cbo=%b ovf=%b required 01 1 0", result, carryborrow_out, overflow);
    end
    tick();
    run_op(1'b0, 1'b0, 1'b1, 8'hFF, 8'h01, lat);
    checks++;
    if (result !== 8'h00 || carryborrow_out !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL add_half_cin result=%h cbo=%b ovf=%b required 00 1 0", result, carryborrow_out, overflow);
    end
    tick();
    run_op(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, lat);
    checks++;
    if (result !== 8'h00 || carryborrow_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_half_bin result=%h cbo=%b ovf=%b required 00 0 0", result, carryborrow_out, overflow);
    end
    tick();
    run_op(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, lat);
    checks++;
    if (result !== 8'hFF || carryborrow_out !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_full_bin result=%h cbo=%b ovf=%b required ff 1 0", result, carryborrow_out, overflow);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int pulses;
    mode_addsub    = 1'b0;
    mode_halffull  = 1'b1;
    carryborrow_in = 1'b0;
    operand_a      = 8'h12;
    operand_b      = 8'h34;
    start          = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        mode_addsub    = 1'b1;
        carryborrow_in = 1'b1;
        operand_a      = 8'hFF;
        operand_b      = 8'hFF;
        start          = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        checks++;
        if (result !== 8'h46 || carryborrow_out !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ignore_result result=%h cbo=%b ovf=%b required 46 0 0", result, carryborrow_out, overflow);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses got=%0d required=1", pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    mode_addsub    = 1'b0;
    mode_halffull  = 1'b1;
    carryborrow_in = 1'b0;
    operand_a      = 8'h55;
    operand_b      = 8'h0F;
    start          = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state busy=%b result=%h done=%b required 0 00 0", busy, result, done);
    end
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d required=0", pulses);
    end
    run_op(1'b0, 1'b1, 1'b0, 8'hC0, 8'hC0, lat);
    checks++;
    if (lat !== 8 || result !== 8'h80 || carryborrow_out !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL abort_fresh lat=%0d result=%h cbo=%b ovf=%b required 8 80 1 0", lat, result, carryborrow_out, overflow);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int first;
    int last;
    int pulses;
    int spacing_bad;
    int prev_done;
    mode_addsub    = 1'b0;
    mode_halffull  = 1'b1;
    carryborrow_in = 1'b0;
    operand_a      = 8'h01;
    operand_b      = 8'h02;
    start          = 1'b1;
    first          = -1;
    last           = -1;
    pulses         = 0;
    spacing_bad    = 0;
    prev_done      = 0;
    for (int t = 1; t <= 35; t++) begin
      tick();
      if (done === 1'b1) begin
        if (prev_done != 0) spacing_bad++;
        if (first < 0) first = t;
        else if (t - last != WIDTH + 2) spacing_bad++;
        last = t;
        pulses++;
        checks++;
        if (result !== 8'h03) begin
          errors++;
          $display("FAIL b2b_result t=%0d result=%h required 03", t, result);
        end
      end
      prev_done = (done === 1'b1) ? 1 : 0;
    end
    start = 1'b0;
    checks++;
    if (first !== 9 || pulses !== 3 || spacing_bad !== 0) begin
      errors++;
      $display("FAIL b2b_timing first=%0d pulses=%0d bad=%0d required 9 3 0", first, pulses, spacing_bad);
    end
    for (int n = 0; n < 12 && busy === 1'b1; n++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain busy=%b required=0", busy);
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b0;
    start          = 1'b0;
    mode_addsub    = 1'b0;
    mode_halffull  = 1'b0;
    carryborrow_in = 1'b0;
    operand_a      = '0;
    operand_b      = '0;
    test_reset();
    test_add();
    test_sub();
    test_halffull();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port: mode_addsub  input  1  0 = add (A+B), 1 = subtract (A-B); captured on accepted start.
REQ-006 SHALL have port: mode_halffull  input  1  0 = bit-0 carry/borrow-in forced 0, 1 = carryborrow_in used; captured on accepted start.
REQ-007 SHALL have port: carryborrow_in  input  1  external carry-in (add) or borrow-in (sub) for bit 0; captured on accepted start.
REQ-008 SHALL have port: operand_a  input  WIDTH  minuend/addend A; captured on accepted start.
REQ-009 SHALL have port: operand_b  input  WIDTH  subtrahend/addend B; captured on accepted start.
REQ-010 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result fields valid.
REQ-012 SHALL have port: result  output  WIDTH  sum or difference.
REQ-013 SHALL have port: carryborrow_out  output  1  carry-out of MSB (add) or borrow-out of MSB (sub).
REQ-014 SHALL have port: overflow  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; encoding free.
REQ-016 In IDLE with start=1 at an edge: SHALL capture operands and modes; load the bit counter with 0; load the carry/borrow register with carryborrow_in AND mode_halffull; go to RUN.
REQ-017 In IDLE with start=0: SHALL stay in IDLE and hold all outputs.
REQ-018 In RUN: SHALL process exactly one bit per edge, LSB first, at index i = counter; a = A[i], b = B[i], c = carry/borrow register.
REQ-019 Per-bit result: SHALL set result bit i = a XOR b XOR c.
REQ-020 Per-bit carry/borrow: SHALL set next c = (c AND (a XOR b XOR mode_addsub)) OR ((a XOR mode_addsub) AND b); the per-bit datapath SHALL be the team addsub_halffull cell driven with mode_halffull=1 and the registered c.
REQ-021 SHALL increment the counter each RUN edge; on the edge processing i = WIDTH-1 it SHALL go to DONE.
REQ-022 On that last edge: carryborrow_out SHALL take next c; overflow SHALL take (c into MSB) XOR (next c).
REQ-023 In DONE: done SHALL be 1 for exactly one cycle; the next edge SHALL go to IDLE unconditionally.
REQ-024 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH.
REQ-025 result, carryborrow_out and overflow SHALL be held from DONE until the edge completing bit 0 of the next operation.
REQ-026 start while busy=1 (RUN or DONE) SHALL be ignored, with no queuing; input changes during RUN SHALL NOT affect the operation.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-028 start in the IDLE cycle immediately following DONE SHALL be accepted normally (back-to-back ops).

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, counter 0, carry/borrow register 0, result 0, carryborrow_out 0, overflow 0, done 0, busy 0.
REQ-030 reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.

Verification (WIDTH=8)
REQ-031 add, full, cin=0, A=0x7F, B=0x01, start at edge k -> done after edge k+8; result=0x80, cout=0, overflow=1.
REQ-032 sub, full, bin=0, A=0x05, B=0x07 -> result=0xFE, borrow=1, overflow=0; sub A=0x80, B=0x01 -> result=0x7F, borrow=0, overflow=1.
REQ-033 add, full, cin=1, A=0xFF, B=0x01 -> result=0x01, cout=1, overflow=0; same stimulus with half mode -> result=0x00, cout=1.
REQ-034 start pulsed during RUN with different operands -> ignored, original result delivered, a single done pulse.
REQ-035 reset asserted at the 4th RUN edge -> next cycle busy=0, result=0, no done; a fresh start then completes correctly.
REQ-036 back-to-back: start held high continuously -> ops accepted every WIDTH+2 cycles, each with a single one-cycle done pulse.
